// File: rtl/crs_if.sv
// CRS system bus between the arbiter (master) and a responder (slave).
//   y_adr      12-bit bus address              master -> slave
//   y_wr_data  16-bit write data               master -> slave
//   y_wr       write strobe, one write/cycle   master -> slave
//   y_rd_data  16-bit registered read data     slave  -> master
interface crs_if;
    logic [11:0] y_adr;
    logic [15:0] y_wr_data;
    logic        y_wr;
    logic [15:0] y_rd_data;

    modport master (output y_adr, y_wr_data, y_wr, input y_rd_data);
    modport slave  (input y_adr, y_wr_data, y_wr, output y_rd_data);
endinterface

// File: rtl/crs_slave.sv
// crs_slave: responder end of the CRS bus.
// Decodes bus cycles into RW control registers, RO status inputs, a one-shot
// pulse register and a write-to-push FIFO draining over valid/ready.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        crs_if slave modport (address, write data/strobe, read data)
//   rw_regs    packed RW registers, reg i at [16*i+15:16*i]
//   ro_regs    packed RO status words, word i at [16*i+15:16*i]
//   pulse      one-cycle strobes written via 0x200
//   tx_data    FIFO head word (0 when empty)
//   tx_valid   FIFO not empty
//   tx_ready   consumer accept
//   tx_ovf     sticky overflow flag, cleared by writing 0x301 with bit15 set
module crs_slave #(
    parameter int          N_RW    = 8,
    parameter int          N_RO    = 8,
    parameter int          FIFO_AW = 4,
    parameter logic [15:0] ID_VAL  = 16'hC0DE
) (
    input  logic                 clk,
    input  logic                 rst,
    crs_if.slave                 bus,
    output logic [16*N_RW-1:0]   rw_regs,
    input  logic [16*N_RO-1:0]   ro_regs,
    output logic [15:0]          pulse,
    output logic [15:0]          tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_ovf
);
    localparam logic [11:0] ADR_RO    = 12'h100;
    localparam logic [11:0] ADR_PULSE = 12'h200;
    localparam logic [11:0] ADR_PUSH  = 12'h300;
    localparam logic [11:0] ADR_STAT  = 12'h301;
    localparam logic [11:0] ADR_ID    = 12'hFFF;
    localparam int          DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

    logic [15:0]        rw_q [N_RW];
    logic [15:0]        mem  [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, push, pop, do_push, ovf_set, ovf_clr;
    logic [15:0]        status, rd_next;

    for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
        assign rw_regs[16*g +: 16] = rw_q[g];
    end

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = tx_valid ? mem[rd_ptr] : 16'h0000;

    assign push     = bus.y_wr && (bus.y_adr == ADR_PUSH);
    assign pop      = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is
    // accepted rather than counted as an overflow.
    assign do_push  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;
    assign ovf_clr  = bus.y_wr && (bus.y_adr == ADR_STAT) && bus.y_wr_data[15];

    always_comb begin
        status            = '0;
        status[15]        = tx_ovf;
        status[14]        = full;
        status[13]        = empty;
        status[FIFO_AW:0] = count;
    end

    // Read decode; unmapped addresses (incl. pulse and push ports) read 0.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_RW; i++)
            if (bus.y_adr == 12'(i)) rd_next = rw_q[i];
        for (int i = 0; i < N_RO; i++)
            if (bus.y_adr == 12'(ADR_RO + 12'(i))) rd_next = ro_regs[16*i +: 16];
        if (bus.y_adr == ADR_STAT) rd_next = status;
        if (bus.y_adr == ADR_ID)   rd_next = ID_VAL;
    end

    // Registered read: samples pre-write state, so a same-cycle write is
    // visible only on the following read.
    always_ff @(posedge clk) begin
        if (rst) bus.y_rd_data <= '0;
        else     bus.y_rd_data <= rd_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RW; i++) rw_q[i] <= '0;
            pulse <= '0;
        end else begin
            for (int i = 0; i < N_RW; i++)
                if (bus.y_wr && bus.y_adr == 12'(i)) rw_q[i] <= bus.y_wr_data;
            pulse <= (bus.y_wr && bus.y_adr == ADR_PULSE) ? bus.y_wr_data : 16'h0000;
        end
    end

    // FIFO storage needs no reset: tx_data is masked by tx_valid.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= bus.y_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Overflow takes priority over a simultaneous clear.
            if (ovf_set)      tx_ovf <= 1'b1;
            else if (ovf_clr) tx_ovf <= 1'b0;
        end
    end
endmodule
